fowd_unit: RTL
==============

# fowd_unit

Operand forwarding and load-use hazard unit for the 16-bit pipelined core. It tracks the two in-flight register writers ahead of EX (the MEM and WB stage records) and drives the `fowd_en`/`fowd_data` pair consumed by each ALU operand mux. When the EX instruction reads a register that an older load has not yet returned, it raises a one-cycle stall.

## Interface
- `DATA_W`, 16, data path width
- `ADDR_W`, 4, register address width: 0–7 = R0–R7, 8 = T, 9 = SP, 10 = IH, 11 = RA, 4'hF = none
- `clk`  in  1  pipeline clock
- `rst`  in  1  asynchronous, active-low reset
- `src_a_addr`  in  ADDR_W  EX-stage operand A register (4'hF = unused)
- `src_b_addr`  in  ADDR_W  EX-stage operand B register (4'hF = unused)
- `ex_valid`  in  1  EX holds a real instruction
- `ex_wr_en`  in  1  EX instruction writes a register
- `ex_wr_addr`  in  ADDR_W  EX destination register
- `ex_is_load`  in  1  EX instruction is a memory load
- `ex_result`  in  DATA_W  EX ALU result
- `mem_rd_data`  in  DATA_W  load data returned in the MEM stage
- `alu_a_fowd_en`  out  1  select forwarded operand A
- `alu_a_fowd_data`  out  DATA_W  forwarded operand A
- `alu_b_fowd_en`  out  1  select forwarded operand B
- `alu_b_fowd_data`  out  DATA_W  forwarded operand B
- `stall`  out  1  load-use hazard; freeze IF/ID/EX this cycle
- `stall_cnt`  out  16  stall statistics counter (see Configuration)

## Operation
- The MEM record holds `{addr, we, is_load, data}`. The WB record holds `{addr, we, data}`.
- A record matches a source when all of the following hold:
  - `we` = 1
  - `addr` == src
  - src != 4'hF
- Operand A and operand B are resolved independently and identically.
- Priority for each operand:
  - MEM match with `is_load` = 0: `fowd_en` = 1, `fowd_data` = MEM.data.
  - MEM match with `is_load` = 1: hazard. `stall` = 1 and `fowd_en` = 0 for that operand.
  - Otherwise, WB match: `fowd_en` = 1, `fowd_data` = WB.data.
  - Otherwise: `fowd_en` = 0 and `fowd_data` = 0.
- `stall` is the OR of the A and B hazards.
- Record update on each clock edge when `stall` = 0:
  - MEM ← `{ex_wr_addr, ex_wr_en & ex_valid, ex_is_load, ex_result}`.
  - WB ← `{MEM.addr, MEM.we, MEM.is_load ? mem_rd_data : MEM.data}`.
- Record update on each clock edge when `stall` = 1:
  - MEM ← bubble `{4'hF, 0, 0, 0}`.
  - WB ← `{MEM.addr, MEM.we, mem_rd_data}`.
  - The EX inputs are not captured; EX re-presents the same instruction next cycle.
- All arithmetic is pass-through. No width conversion.

## Timing
- Forwarding outputs and `stall` are combinational from the current records and the `src_*` inputs. Zero-cycle latency.
- Records update on the `posedge clk`.
- Reset is asynchronous on `negedge rst`. Both records clear to `{4'hF, 0, 0, 0}`. As a result:
  - `alu_*_fowd_en` = 0, `alu_*_fowd_data` = 0
  - `stall` = 0
  - `stall_cnt` = 0
- A load-use hazard stalls exactly one cycle. The following cycle, the consumer forwards from WB.
- Back-to-back dependence on the same register: MEM wins over WB (youngest value).
- An operand with src = 4'hF never forwards and never stalls.
- `ex_valid` = 0 inserts a bubble (`we` = 0), independent of `ex_wr_en`.
- Reset asserted mid-stall: records clear immediately; `stall` drops in the same cycle.

## Configuration
- `FOWD_STALL_CNT_EN` defined:
  - `stall_cnt` increments by 1 on every clock edge where `stall` = 1.
  - It saturates at 16'hFFFF.
- `FOWD_STALL_CNT_EN` undefined:
  - The counter logic is omitted.
  - `stall_cnt` is tied to 0.
- Forwarding and stall behaviour are identical in both builds.

## Test plan
- Reset, then idle with src = 4'hF: `alu_*_fowd_en` = 0, `stall` = 0, `stall_cnt` = 0.
- EX: write R3 = 16'h1234 (ALU). Next cycle src_a = R3 → `alu_a_fowd_en` = 1, `alu_a_fowd_data` = 16'h1234. Cycle after, src_b = R3 → forwarded from WB, 16'h1234.
- EX: load R2. Next cycle src_a = R2 → `stall` = 1 for one cycle, with `mem_rd_data` = 16'hBEEF. Following cycle → `stall` = 0, `alu_a_fowd_data` = 16'hBEEF.
- Two consecutive writes to SP: 16'h0010 then 16'h0020. Consumer of SP → MEM wins, forwards 16'h0020.
- `ex_valid` = 0 with `ex_wr_en` = 1 to R1. Next cycle src_a = R1 → no forward, no stall.
- With `FOWD_STALL_CNT_EN`: three load-use stalls → `stall_cnt` = 3. Assert `rst` low mid-stall → `stall` = 0, `stall_cnt` = 0 immediately. Without the macro, `stall_cnt` stays 0 throughout.

Source files
------------

// File: rtl/fowd_unit.sv
// Operand forwarding and load-use hazard unit: MEM/WB writer records, per-operand bypass mux, one-cycle load-use stall.
// Optional stall statistics counter is built only when FOWD_STALL_CNT_EN is defined.
module fowd_unit #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] src_a_addr,
    input  logic [ADDR_W-1:0] src_b_addr,
    input  logic              ex_valid,
    input  logic              ex_wr_en,
    input  logic [ADDR_W-1:0] ex_wr_addr,
    input  logic              ex_is_load,
    input  logic [DATA_W-1:0] ex_result,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              alu_a_fowd_en,
    output logic [DATA_W-1:0] alu_a_fowd_data,
    output logic              alu_b_fowd_en,
    output logic [DATA_W-1:0] alu_b_fowd_data,
    output logic              stall,
    output logic [15:0]       stall_cnt
);

    localparam logic [ADDR_W-1:0] ADDR_NONE = {ADDR_W{1'b1}};

    logic [ADDR_W-1:0] mem_addr_r;
    logic              mem_we_r;
    logic              mem_load_r;
    logic [DATA_W-1:0] mem_data_r;
    logic [ADDR_W-1:0] wb_addr_r;
    logic              wb_we_r;
    logic [DATA_W-1:0] wb_data_r;

    logic [DATA_W+1:0] res_a_s;
    logic [DATA_W+1:0] res_b_s;
    logic              stall_s;

    // Result packing: {hazard, fowd_en, fowd_data}; the younger MEM record shadows WB.
    function automatic logic [DATA_W+1:0] resolve(
        input logic [ADDR_W-1:0] src,
        input logic [ADDR_W-1:0] m_addr,
        input logic              m_we,
        input logic              m_load,
        input logic [DATA_W-1:0] m_data,
        input logic [ADDR_W-1:0] w_addr,
        input logic              w_we,
        input logic [DATA_W-1:0] w_data
    );
        logic [DATA_W+1:0] r;
        r = {1'b0, 1'b0, {DATA_W{1'b0}}};
        if (src == ADDR_NONE) begin
            r = {1'b0, 1'b0, {DATA_W{1'b0}}};
        end else if (m_we && (m_addr == src)) begin
            if (m_load) begin
                r = {1'b1, 1'b0, {DATA_W{1'b0}}};
            end else begin
                r = {1'b0, 1'b1, m_data};
            end
        end else if (w_we && (w_addr == src)) begin
            r = {1'b0, 1'b1, w_data};
        end else begin
            r = {1'b0, 1'b0, {DATA_W{1'b0}}};
        end
        return r;
    endfunction

    // Operand resolution and hazard detection from the current records
    always_comb begin
        res_a_s = resolve(src_a_addr, mem_addr_r, mem_we_r, mem_load_r, mem_data_r,
                          wb_addr_r, wb_we_r, wb_data_r);
        res_b_s = resolve(src_b_addr, mem_addr_r, mem_we_r, mem_load_r, mem_data_r,
                          wb_addr_r, wb_we_r, wb_data_r);
        stall_s = res_a_s[DATA_W+1] | res_b_s[DATA_W+1];
    end

    assign alu_a_fowd_en   = res_a_s[DATA_W];
    assign alu_a_fowd_data = res_a_s[DATA_W-1:0];
    assign alu_b_fowd_en   = res_b_s[DATA_W];
    assign alu_b_fowd_data = res_b_s[DATA_W-1:0];
    assign stall           = stall_s;

    // MEM/WB record pipeline; a stall injects a bubble into MEM while the load retires
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_addr_r <= ADDR_NONE;
            mem_we_r   <= 1'b0;
            mem_load_r <= 1'b0;
            mem_data_r <= {DATA_W{1'b0}};
            wb_addr_r  <= ADDR_NONE;
            wb_we_r    <= 1'b0;
            wb_data_r  <= {DATA_W{1'b0}};
        end else if (stall_s) begin
            mem_addr_r <= ADDR_NONE;
            mem_we_r   <= 1'b0;
            mem_load_r <= 1'b0;
            mem_data_r <= {DATA_W{1'b0}};
            wb_addr_r  <= mem_addr_r;
            wb_we_r    <= mem_we_r;
            wb_data_r  <= mem_rd_data;
        end else begin
            mem_addr_r <= ex_wr_addr;
            mem_we_r   <= ex_wr_en & ex_valid;
            mem_load_r <= ex_is_load;
            mem_data_r <= ex_result;
            wb_addr_r  <= mem_addr_r;
            wb_we_r    <= mem_we_r;
            wb_data_r  <= mem_load_r ? mem_rd_data : mem_data_r;
        end
    end

`ifdef FOWD_STALL_CNT_EN
    logic [15:0] stall_cnt_r;

    // Saturating count of stalled cycles
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_r <= 16'h0000;
        end else if (stall_s && (stall_cnt_r != 16'hFFFF)) begin
            stall_cnt_r <= stall_cnt_r + 16'h0001;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign stall_cnt = stall_cnt_r;
`else
    assign stall_cnt = 16'h0000;
`endif

endmodule
